car_sensor_gen: RTL and testbench

CAR_SENSOR_GEN -- requirements
Module: car_sensor_gen

---
 rtl/car_sensor_gen.sv | 135 +++++++++++++
 tb/tb_car_sensor_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/car_sensor_gen.sv
// Emulates a car passing a two-beam sensor pair (A, B) in the entry or exit direction.
// Each phase is held for STEP_CYCLES clocks. Completed passes are counted per direction.
module car_sensor_gen #(
  parameter int unsigned STEP_CYCLES = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go_in,
  input  logic             go_out,
  output logic             A,
  output logic             B,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P1   = 3'd1;
  localparam logic [2:0] S_P2   = 3'd2;
  localparam logic [2:0] S_P3   = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  localparam logic [15:0] DWELL_LAST = 16'(STEP_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic             dir_q, dir_d;      // 0 = entry, 1 = exit
  logic [15:0]      dwell_q, dwell_d;
  logic [1:0]       ab_q, ab_d;        // {A, B}
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_in_q, cnt_in_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;

  logic dwell_end;

  assign dwell_end = (dwell_q == DWELL_LAST);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    dwell_d   = dwell_q;
    done_d    = 1'b0;
    cnt_in_d  = cnt_in_q;
    cnt_out_d = cnt_out_q;

    // Requests are rejected while busy, or when both directions collide in idle.
    if (state_q == S_IDLE) begin
      err_d = go_in & go_out;
    end else begin
      err_d = go_in | go_out;
    end

    case (state_q)
      S_IDLE: begin
        if (go_in ^ go_out) begin
          state_d = S_P1;
          dir_d   = go_out;
          dwell_d = 16'd0;
        end
      end
      S_P1, S_P2, S_P3, S_GAP: begin
        if (dwell_end) begin
          dwell_d = 16'd0;
          case (state_q)
            S_P1:    state_d = S_P2;
            S_P2:    state_d = S_P3;
            S_P3:    state_d = S_GAP;
            default: begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              if (dir_q) begin
                cnt_out_d = cnt_out_q + CNT_W'(1);
              end else begin
                cnt_in_d  = cnt_in_q + CNT_W'(1);
              end
            end
          endcase
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        dwell_d = 16'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);

    // Sensor levels follow the next state so they switch on the same edge as the state.
    case (state_d)
      S_P1:    ab_d = dir_d ? 2'b10 : 2'b01;
      S_P2:    ab_d = 2'b11;
      S_P3:    ab_d = dir_d ? 2'b01 : 2'b10;
      default: ab_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      dwell_q   <= 16'd0;
      ab_q      <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      dwell_q   <= dwell_d;
      ab_q      <= ab_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cnt_in_q  <= cnt_in_d;
      cnt_out_q <= cnt_out_d;
    end
  end

  assign A       = ab_q[1];
  assign B       = ab_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign cnt_in  = cnt_in_q;
  assign cnt_out = cnt_out_q;

endmodule

// File: tb/tb_car_sensor_gen.sv
// Bench for car_sensor_gen: two configurations (STEP=3/CNT_W=8 and STEP=1/CNT_W=2),
// each checked cycle by cycle against a timeline model through an expected queue.
module tb_car_sensor_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int S  = (g == 0) ? 3 : 1;
    localparam int CW = (g == 0) ? 8 : 2;

    logic          rst, go_in, go_out;
    logic          a, b, busy, done, err;
    logic [CW-1:0] ci, co;

    car_sensor_gen #(.STEP_CYCLES(S), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .go_in(go_in), .go_out(go_out),
      .A(a), .B(b), .busy(busy), .done(done), .err(err),
      .cnt_in(ci), .cnt_out(co)
    );

    // {A,B,busy,done,err,cnt_in[7:0],cnt_out[7:0]}
    logic [20:0] exp_q[$];
    bit          drv_done = 1'b0;

    int cyc  = 0;
    int t0   = 0;
    bit in_seq = 1'b0;
    bit dir    = 1'b0;
    int m_ci = 0;
    int m_co = 0;

    function automatic logic [1:0] ab_of(bit d, int k);
      case (k)
        0:       return d ? 2'b10 : 2'b01;
        1:       return 2'b11;
        2:       return d ? 2'b01 : 2'b10;
        default: return 2'b00;
      endcase
    endfunction

    // Model: a sequence is a timeline of 4*S cycles from its acceptance edge.
    always @(posedge clk) begin
      bit         e_done, e_err;
      logic [1:0] ab;
      e_done = 1'b0;
      e_err  = 1'b0;
      ab     = 2'b00;
      if (rst) begin
        in_seq = 1'b0;
        m_ci   = 0;
        m_co   = 0;
      end else if (in_seq) begin
        e_err = go_in | go_out;
        if (cyc - t0 == 4 * S) begin
          in_seq = 1'b0;
          e_done = 1'b1;
          if (dir) m_co = (m_co + 1) % (1 << CW);
          else     m_ci = (m_ci + 1) % (1 << CW);
        end
      end else begin
        e_err = go_in & go_out;
        if (go_in ^ go_out) begin
          in_seq = 1'b1;
          dir    = go_out;
          t0     = cyc;
        end
      end
      if (in_seq) ab = ab_of(dir, (cyc - t0) / S);
      exp_q.push_back({ab, in_seq, e_done, e_err, 8'(m_ci), 8'(m_co)});
      cyc++;
    end

    always @(negedge clk) begin
      logic [20:0] got, exp_v;
      if (cyc > 0) begin
        got = {a, b, busy, done, err, 8'(ci), 8'(co)};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL inst%0d cyc=%0d out_vec: got=%h required=<expected entry>", g, cyc, got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            failures++;
            $display("FAIL inst%0d cyc=%0d out_vec {A,B,busy,done,err,cin,cout}: got=%h required=%h",
                     g, cyc, got, exp_v);
          end
        end
      end
    end

    task automatic cycles(int n);
      repeat (n) @(negedge clk);
    endtask

    initial begin
      rst = 1'b1; go_in = 1'b0; go_out = 1'b0;
      cycles(3);
      rst = 1'b0;
      // single entry, then single exit
      go_in = 1'b1;  cycles(1); go_in = 1'b0;  cycles(4 * S + 2);
      go_out = 1'b1; cycles(1); go_out = 1'b0; cycles(4 * S + 2);
      // collision in idle
      go_in = 1'b1; go_out = 1'b1; cycles(1); go_in = 1'b0; go_out = 1'b0; cycles(2);
      // exit request during entry P2
      go_in = 1'b1; cycles(1); go_in = 1'b0; cycles(S + 1);
      go_out = 1'b1; cycles(1); go_out = 1'b0; cycles(4 * S);
      // reset during P3
      go_in = 1'b1; cycles(1); go_in = 1'b0; cycles(2 * S + 1);
      rst = 1'b1; cycles(1); rst = 1'b0; cycles(2);
      // go_in held: back-to-back entries through a counter wrap
      go_in = 1'b1; cycles(5 * (4 * S + 1) + 2); go_in = 1'b0; cycles(4 * S + 3);
      // random traffic with occasional resets
      repeat (400) begin
        go_in  = ($urandom_range(0, 7) == 0);
        go_out = ($urandom_range(0, 7) == 0);
        rst    = ($urandom_range(0, 99) == 0);
        cycles(1);
      end
      rst = 1'b0; go_in = 1'b0; go_out = 1'b0;
      cycles(4 * S + 3);
      drv_done = 1'b1;
    end
  end

  initial begin
    int budget;
    budget = 20000;
    while (!(inst[0].drv_done && inst[1].drv_done) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      failures++;
      $display("FAIL drivers_timeout: got=budget_expired required=drivers_finished");
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
